// File: rtl/updi_phy_pkg.sv
// Shared definitions for the UPDI UART PHY: frame layout, FSM states and
// the receive error decode.
package updi_phy_pkg;
  localparam int FRAME_W = 12;
  localparam int START   = 0;
  localparam int PAR     = 9;
  localparam int STOP0   = 10;
  localparam int STOP1   = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_BIT  = 3'd1,
    GUARD   = 3'd2,
    RX_HALF = 3'd3,
    RX_BIT  = 3'd4
  } phy_state_e;

  // [0] parity error (even parity over data+par), [1] framing error
  function automatic logic [1:0] frame_err(input logic [FRAME_W-1:0] f);
    return {f[START] | ~f[STOP0] | ~f[STOP1], ^f[PAR:1]};
  endfunction
endpackage

// File: rtl/updi_baud_cnt.sv
// Bit timer: loads a full- or half-bit count and flags expiry when it hits
// zero. The divider is clamped to a minimum of 4 clocks per bit.
module updi_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             half_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             expire_o
);
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] reload;

  assign div_eff  = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;
  assign reload   = half_i ? (div_eff >> 1) - DIV_W'(1) : div_eff - DIV_W'(1);
  assign expire_o = (cnt_q == '0);

  // div_i is only looked at on a load, so a divider change lands on the next bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (load_i)      cnt_q <= reload;
    else if (!expire_o)   cnt_q <= cnt_q - DIV_W'(1);
  end
endmodule

// File: rtl/updi_uart_phy.sv
// Half-duplex UPDI UART PHY: sends 12-bit frames with trailing guard time
// and receives 12-bit frames with parity/framing error flags.
module updi_uart_phy
  import updi_phy_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int GUARD_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [FRAME_W-1:0] tx_frame,
  output logic               rx_valid,
  output logic [FRAME_W-1:0] rx_frame,
  output logic [1:0]         rx_err,
  input  logic               line_i,
  output logic               line_o,
  output logic               line_oe,
  output logic               busy
);
  localparam logic [7:0] LAST_BIT   = 8'(STOP1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_BITS - 1);

  phy_state_e         state_q, state_d;
  logic [1:0]         sync_q;
  logic               line_s;
  logic [7:0]         bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] txf_q, txf_d;
  logic [FRAME_W-1:0] rxsh_q, rxsh_d;
  logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
  logic [1:0]         rx_err_q, rx_err_d;
  logic               rx_valid_q, rx_valid_d;
  logic               armed_q, armed_d;
  logic               load, half, expire;

  assign line_s   = sync_q[1];
  assign tx_ready = (state_q == IDLE) && line_s && !rst;
  assign line_oe  = (state_q == TX_BIT);
  assign line_o   = (state_q == TX_BIT) ? txf_q[bitcnt_q[3:0]] : 1'b1;
  assign busy     = (state_q != IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_frame = rx_frame_q;
  assign rx_err   = rx_err_q;

  updi_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .half_i   (half),
    .div_i    (baud_div),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      bitcnt_q   <= '0;
      txf_q      <= '0;
      rxsh_q     <= '0;
      rx_frame_q <= '0;
      rx_err_q   <= '0;
      rx_valid_q <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], line_i};
      bitcnt_q   <= bitcnt_d;
      txf_q      <= txf_d;
      rxsh_q     <= rxsh_d;
      rx_frame_q <= rx_frame_d;
      rx_err_q   <= rx_err_d;
      rx_valid_q <= rx_valid_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    txf_d      = txf_q;
    rxsh_d     = rxsh_q;
    rx_frame_d = rx_frame_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = 1'b0;
    // a held-low line (break) disarms rx until the line is seen high again
    armed_d    = armed_q | line_s;
    load       = 1'b0;
    half       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!line_s && armed_q) begin
          state_d = RX_HALF;
          load    = 1'b1;
          half    = 1'b1;
        end else if (tx_valid && tx_ready) begin
          txf_d    = tx_frame;
          bitcnt_d = '0;
          load     = 1'b1;
          state_d  = TX_BIT;
        end
      end
      TX_BIT: begin
        if (expire) begin
          load = 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            state_d  = (GUARD_BITS == 0) ? IDLE : GUARD;
          end else begin
            bitcnt_d = bitcnt_q + 8'd1;
          end
        end
      end
      GUARD: begin
        if (expire) begin
          if (bitcnt_q == GUARD_LAST) begin
            state_d = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 8'd1;
            load     = 1'b1;
          end
        end
      end
      RX_HALF: begin
        if (expire) begin
          if (line_s) begin
            state_d = IDLE;
          end else begin
            rxsh_d        = '0;
            rxsh_d[START] = line_s;
            bitcnt_d      = 8'd1;
            load          = 1'b1;
            state_d       = RX_BIT;
          end
        end
      end
      RX_BIT: begin
        if (expire) begin
          rxsh_d[bitcnt_q[3:0]] = line_s;
          if (bitcnt_q == LAST_BIT) begin
            rx_frame_d = rxsh_d;
            rx_err_d   = frame_err(rxsh_d);
            rx_valid_d = 1'b1;
            armed_d    = line_s;
            state_d    = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 8'd1;
            load     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
